// File: rtl/dekatron_pkg.sv
// -----------------------------------------------------------------------------
// dekatron_pkg
//   Shared types for the dekatron register input path.
//   - bcd_digit_t     : one packed BCD digit (4 bits)
//   - BCD_MAX         : largest legal BCD value; larger nibbles are clamped to it
//   - loader_state_t  : states of the BCD pulse loader sequencer
//   - clamp_bcd()     : saturates a nibble to BCD_MAX
// -----------------------------------------------------------------------------
package dekatron_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PULSE_HI,
    PULSE_LO,
    DONE
  } loader_state_t;

  // A dekatron counter only has ten positions, so an out-of-range nibble is
  // loaded as 9 rather than wrapping around the tube.
  function automatic bcd_digit_t clamp_bcd(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage : dekatron_pkg

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter that times one sequencer phase. Loading N makes
//   expire_o high in the N-th cycle after the load edge (the count is 1 then),
//   so a phase lasting N cycles is timed by loading N on the edge that enters it.
//   The count stops at 0 when not reloaded.
// Ports
//   clk_i       in  1  clock, rising edge
//   rst_i       in  1  synchronous active-high reset, clears the count
//   load_i      in  1  load load_val_i on this edge (takes priority)
//   load_val_i  in  W  phase length in cycles (>=1 when used)
//   expire_o    out 1  last cycle of the phase (count == 1)
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule : phase_timer

// File: rtl/bcd_pulse_loader.sv
// -----------------------------------------------------------------------------
// bcd_pulse_loader
//   Loads a DIGITS-digit BCD word into a dekatron register. Every load first
//   holds Clr for CLR_CYCLES, then sends increment pulses to all digits in
//   parallel; digit i receives exactly min(nibble_i, 9) pulses. A load lasts
//   CLR_CYCLES + max_digit*(PULSE_HIGH+PULSE_LOW) + 1 cycles up to Done.
// Ports
//   Clk       in   1         clock, rising edge
//   Rst       in   1         synchronous active-high reset, aborts a load
//   In_valid  in   1         In_bcd holds a word to load
//   In_bcd    in   4*DIGITS  BCD word, digit 0 in bits [3:0]
//   In_ready  out  1         idle and out of reset, a word can be accepted
//   Clr       out  1         clear strobe to all digit counters (registered)
//   Pulse     out  DIGITS    per-digit increment strobe (registered)
//   Busy      out  1         load in progress (registered)
//   Done      out  1         one-cycle strobe when a load finishes (registered)
//   Err       out  1         last accepted word had a digit > 9 (registered)
// -----------------------------------------------------------------------------
module bcd_pulse_loader
  import dekatron_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int CLR_CYCLES = 2,
  parameter int PULSE_HIGH = 1,
  parameter int PULSE_LOW  = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                In_valid,
  input  logic [4*DIGITS-1:0] In_bcd,
  output logic                In_ready,
  output logic                Clr,
  output logic [DIGITS-1:0]   Pulse,
  output logic                Busy,
  output logic                Done,
  output logic                Err
);

  // One timer serves all three timed phases, so it is sized for the longest.
  localparam int MAX_HL  = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int MAX_DUR = (CLR_CYCLES > MAX_HL) ? CLR_CYCLES : MAX_HL;
  localparam int TW      = $clog2(MAX_DUR + 1);

  localparam logic [TW-1:0] CLR_LOAD = TW'(CLR_CYCLES);
  localparam logic [TW-1:0] HI_LOAD  = TW'(PULSE_HIGH);
  localparam logic [TW-1:0] LO_LOAD  = TW'(PULSE_LOW);

  loader_state_t state_q, state_d;

  logic          accept;
  logic          dec;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          expire;

  logic [DIGITS-1:0] nz_q;   // remain[i] != 0, current value
  logic [DIGITS-1:0] nz_d;   // remain[i] != 0, value after this edge
  logic [DIGITS-1:0] over;   // nibble i of In_bcd is above 9

  logic              clr_q,   clr_d;
  logic [DIGITS-1:0] pulse_q, pulse_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Ready is combinational so it drops in the same cycle Rst is asserted and
  // the word is sampled only on the accept edge itself.
  assign In_ready = (state_q == IDLE) & ~Rst;
  assign accept   = In_valid & In_ready;

  // ---------------------------------------------------------------------------
  // Per-digit remain counters
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_t nibble;
    bcd_digit_t remain_q;
    bcd_digit_t remain_d;

    assign nibble  = In_bcd[4*i +: 4];
    assign over[i] = (nibble > BCD_MAX);

    always_comb begin
      remain_d = remain_q;
      if (accept) begin
        remain_d = clamp_bcd(nibble);
      end else if (dec && (remain_q != '0)) begin
        remain_d = remain_q - 4'd1;
      end
    end

    // NOTE: these are individual counters, not a RAM array, so each one is
    // reset; an abort must never leave stale counts for the next word.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        remain_q <= '0;
      end else begin
        remain_q <= remain_d;
      end
    end

    assign nz_q[i] = (remain_q != '0);
    assign nz_d[i] = (remain_d != '0);
  end : g_digit

  // ---------------------------------------------------------------------------
  // Sequencer: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CLEAR;
      end
      CLEAR: begin
        if (expire) state_d = (nz_q == '0) ? DONE : PULSE_HI;
      end
      PULSE_HI: begin
        // Counts drop on the edge leaving the high phase, so the low phase
        // already sees the remaining pulse counts.
        if (expire) begin
          dec     = 1'b1;
          state_d = PULSE_LO;
        end
      end
      PULSE_LO: begin
        if (expire) state_d = (nz_q == '0) ? DONE : PULSE_HI;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The timer is reloaded on every state change with the length of the phase
  // being entered; IDLE and DONE are not timed.
  always_comb begin
    timer_load = (state_d != state_q);
    timer_val  = '0;
    unique case (state_d)
      CLEAR:    timer_val = CLR_LOAD;
      PULSE_HI: timer_val = HI_LOAD;
      PULSE_LO: timer_val = LO_LOAD;
      default:  timer_val = '0;
    endcase
  end

  phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expire_o   (expire)
  );

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the state being entered
  // ---------------------------------------------------------------------------
  // Pulse uses the post-edge counts: in PULSE_HI they equal the counts before
  // the decrement, so a digit pulses exactly as many times as it was loaded.
  always_comb begin
    clr_d   = (state_d == CLEAR);
    pulse_d = (state_d == PULSE_HI) ? nz_d : '0;
    busy_d  = (state_d == CLEAR) || (state_d == PULSE_HI) || (state_d == PULSE_LO);
    done_d  = (state_d == DONE);
    err_d   = accept ? (|over) : err_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Clr   = clr_q;
  assign Pulse = pulse_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Err   = err_q;

endmodule : bcd_pulse_loader

// File: tb/tb_bcd_pulse_loader.sv
// -----------------------------------------------------------------------------
// tb_bcd_pulse_loader
//   Directed and random loads of bcd_pulse_loader. Expected pulse counts,
//   latency and error flag come from the behavioural rules of the loader:
//   pulses = min(nibble, 9), latency = CLR + max*(HIGH+LOW) + 1.
// -----------------------------------------------------------------------------
module tb_bcd_pulse_loader;

  localparam int DIGITS     = 3;
  localparam int CLR_CYCLES = 2;
  localparam int PULSE_HIGH = 1;
  localparam int PULSE_LOW  = 1;
  localparam int MAX_WAIT   = 200;

  logic                Clk = 1'b0;
  logic                Rst;
  logic                In_valid;
  logic [4*DIGITS-1:0] In_bcd;
  logic                In_ready;
  logic                Clr;
  logic [DIGITS-1:0]   Pulse;
  logic                Busy;
  logic                Done;
  logic                Err;

  int total = 0;
  int bad   = 0;

  bcd_pulse_loader #(
    .DIGITS     (DIGITS),
    .CLR_CYCLES (CLR_CYCLES),
    .PULSE_HIGH (PULSE_HIGH),
    .PULSE_LOW  (PULSE_LOW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .In_valid (In_valid),
    .In_bcd   (In_bcd),
    .In_ready (In_ready),
    .Clr      (Clr),
    .Pulse    (Pulse),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int ref_pulses(input logic [4*DIGITS-1:0] w, input int i);
    int n;
    n = int'(w[4*i +: 4]);
    return (n > 9) ? 9 : n;
  endfunction

  function automatic int ref_latency(input logic [4*DIGITS-1:0] w);
    int mx = 0;
    for (int i = 0; i < DIGITS; i++)
      if (ref_pulses(w, i) > mx) mx = ref_pulses(w, i);
    return CLR_CYCLES + mx * (PULSE_HIGH + PULSE_LOW) + 1;
  endfunction

  function automatic int ref_err(input logic [4*DIGITS-1:0] w);
    int e = 0;
    for (int i = 0; i < DIGITS; i++)
      if (int'(w[4*i +: 4]) > 9) e = 1;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // One complete load: wait for ready, present w, observe the whole load.
  // After the accept edge In_bcd is replaced by nxt and In_valid by hold.
  // Returns at the negedge of the cycle after Done.
  // ---------------------------------------------------------------------------
  task automatic run_load(input logic [4*DIGITS-1:0] w, input logic [4*DIGITS-1:0] nxt,
                          input bit hold, input string tag);
    int                waited    = 0;
    int                done_cyc  = 0;
    int                clr_cnt   = 0;
    int                clr_first = 0;
    int                busy_cnt  = 0;
    int                busy_done = -1;
    int                err_done  = -1;
    int                overlap   = 0;
    int                edges [DIGITS];
    logic [DIGITS-1:0] prev = '0;

    foreach (edges[i]) edges[i] = 0;

    while (!In_ready && waited < MAX_WAIT) begin
      @(negedge Clk);
      waited++;
    end
    check({tag, "/ready_before"}, int'(In_ready), 1);

    In_valid = 1'b1;
    In_bcd   = w;
    @(posedge Clk);            // accept edge, cycle 0
    @(negedge Clk);            // cycle 1
    In_valid = hold;
    In_bcd   = nxt;

    for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
      if (Clr) begin
        clr_cnt++;
        if (clr_first == 0) clr_first = cyc;
      end
      if (Clr && (Pulse != '0)) overlap++;
      for (int i = 0; i < DIGITS; i++)
        if (Pulse[i] && !prev[i]) edges[i]++;
      prev = Pulse;
      if (Done) begin
        done_cyc  = cyc;
        busy_done = int'(Busy);
        err_done  = int'(Err);
        break;
      end
      if (Busy) busy_cnt++;
      @(negedge Clk);
    end

    check({tag, "/done_cycle"}, done_cyc, ref_latency(w));
    check({tag, "/clr_first"}, clr_first, 1);
    check({tag, "/clr_cycles"}, clr_cnt, CLR_CYCLES);
    check({tag, "/clr_pulse_overlap"}, overlap, 0);
    for (int i = 0; i < DIGITS; i++)
      check($sformatf("%s/pulses_d%0d", tag, i), edges[i], ref_pulses(w, i));
    check({tag, "/busy_cycles"}, busy_cnt, ref_latency(w) - 1);
    check({tag, "/busy_at_done"}, busy_done, 0);
    check({tag, "/err"}, err_done, ref_err(w));

    @(negedge Clk);            // cycle after Done
    check({tag, "/ready_after"}, int'(In_ready), 1);
    check({tag, "/done_single"}, int'(Done), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int done_seen;
    logic [4*DIGITS-1:0] rw;

    Rst      = 1'b1;
    In_valid = 1'b0;
    In_bcd   = '0;
    repeat (3) @(negedge Clk);

    // Reset state
    check("rst/in_ready", int'(In_ready), 0);
    check("rst/clr",      int'(Clr), 0);
    check("rst/pulse",    int'(Pulse), 0);
    check("rst/busy",     int'(Busy), 0);
    check("rst/done",     int'(Done), 0);
    check("rst/err",      int'(Err), 0);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst/ready_after_release", int'(In_ready), 1);

    // 1. 'A' -> digits 5,6,0
    run_load(12'h065, 12'hFFF, 1'b0, "t1");
    // 2. all zero -> clear only
    run_load(12'h000, 12'h999, 1'b0, "t2");
    // 3. digit 2 stops pulsing early
    run_load(12'h255, 12'h000, 1'b0, "t3");
    // 4. out-of-range digit clamps and flags, next word clears the flag
    run_load(12'h0A3, 12'h777, 1'b0, "t4");
    run_load(12'h001, 12'h888, 1'b0, "t4b");
    // 5. In_valid held across two words, second word changes mid-load
    run_load(12'h321, 12'h047, 1'b1, "t5a");
    run_load(12'h047, 12'h000, 1'b0, "t5b");

    // 6. Reset in the 4th high pulse of 12'h099
    check("t6/ready_before", int'(In_ready), 1);
    In_valid = 1'b1;
    In_bcd   = 12'h099;
    @(posedge Clk);
    @(negedge Clk);            // cycle 1
    In_valid = 1'b0;
    repeat (8) @(negedge Clk); // cycle 9 = 4th PULSE_HI
    check("t6/pulse_hi4", int'(Pulse), 3);
    check("t6/busy_hi4",  int'(Busy), 1);
    Rst = 1'b1;
    @(negedge Clk);
    check("t6/abort_clr",   int'(Clr), 0);
    check("t6/abort_pulse", int'(Pulse), 0);
    check("t6/abort_busy",  int'(Busy), 0);
    check("t6/abort_done",  int'(Done), 0);
    check("t6/abort_err",   int'(Err), 0);
    check("t6/abort_ready", int'(In_ready), 0);
    Rst = 1'b0;
    done_seen = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Done) done_seen++;
    end
    check("t6/no_done", done_seen, 0);
    check("t6/ready_after", int'(In_ready), 1);
    run_load(12'h002, 12'h000, 1'b0, "t6b");

    // Random words, including out-of-range nibbles
    for (int n = 0; n < 24; n++) begin
      rw = 12'($urandom);
      run_load(rw, 12'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      In_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_bcd_pulse_loader
